// File: rtl/dtm_dmi_access.sv
// dtm_dmi_access: DMI data register, request issue and response pop for the JTAG DTM,
// tracking the sticky dmistat error reported through dtmcs.
module dtm_dmi_access #(
  parameter int ABITS = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dmi_select_i,
  input  logic             capture_dr_i,
  input  logic             shift_dr_i,
  input  logic             update_dr_i,
  input  logic             tdi_i,
  output logic             tdo_o,
  input  logic             dmi_clear_i,
  input  logic             dmi_hardreset_i,
  output logic [1:0]       dmi_status_o,
  output logic             dmi_rst_no,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [1:0]       dmi_req_op_o,
  output logic [31:0]      dmi_req_data_o,
  input  logic             dmi_resp_valid_i,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_resp_i,
  output logic             dmi_resp_ready_o
);
  localparam int W = ABITS + 34;
  typedef enum logic [2:0] {IDLE, READ, WAIT_READ, WRITE, WAIT_WRITE} state_e;
  state_e           state_q, state_d;
  logic [W-1:0]     dr_q, dr_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       error_q, error_d;
  logic             rst_n_q;
  logic             cap, upd, sh, req, waiting, pop;
  // Strobe priority: capture > update > shift
  assign cap     = dmi_select_i & capture_dr_i;
  assign upd     = dmi_select_i & update_dr_i & ~capture_dr_i;
  assign sh      = dmi_select_i & shift_dr_i & ~capture_dr_i & ~update_dr_i;
  assign req     = (state_q == READ) || (state_q == WRITE);
  assign waiting = (state_q == WAIT_READ) || (state_q == WAIT_WRITE);
  assign pop     = waiting & dmi_resp_valid_i & ~dmi_hardreset_i;
  assign tdo_o            = dr_q[0];
  assign dmi_status_o     = error_q;
  assign dmi_rst_no       = rst_n_q;
  assign dmi_req_valid_o  = req;
  assign dmi_req_addr_o   = req ? addr_q : '0;
  assign dmi_req_data_o   = req ? data_q : '0;
  assign dmi_req_op_o     = (state_q == READ) ? 2'd1 : (state_q == WRITE) ? 2'd2 : 2'd0;
  assign dmi_resp_ready_o = pop;
  always_comb begin
    state_d = state_q;
    dr_d    = dr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    error_d = error_q;
    case (state_q)
      READ:  if (dmi_req_ready_i) state_d = WAIT_READ;
      WRITE: if (dmi_req_ready_i) state_d = WAIT_WRITE;
      WAIT_READ, WAIT_WRITE:
        if (pop) begin
          state_d = IDLE;
          if (state_q == WAIT_READ) data_d = dmi_resp_data_i;
          if (error_q == 2'd0) error_d = dmi_resp_resp_i;
        end
      default: ;
    endcase
    // Capture reads the pre-pop registers, so a capture racing a pop still flags busy
    if (cap) begin
      dr_d = {addr_q, data_q, error_q};
      if (state_q != IDLE) error_d = 2'd3;
    end else if (upd && error_q == 2'd0) begin
      if (state_q != IDLE) error_d = 2'd3;
      else begin
        addr_d  = dr_q[W-1:34];
        data_d  = dr_q[33:2];
        state_d = (dr_q[1:0] == 2'd1) ? READ : (dr_q[1:0] == 2'd2) ? WRITE : IDLE;
      end
    end else if (sh) dr_d = {tdi_i, dr_q[W-1:1]};
    if (dmi_clear_i) error_d = 2'd0;
    if (dmi_hardreset_i) begin
      state_d = IDLE;
      dr_d    = dr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      error_d = 2'd0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= '0;
      rst_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
      rst_n_q <= ~dmi_hardreset_i;
    end
  end
endmodule

// File: tb/tb_dtm_dmi_access.sv
// tb_dtm_dmi_access: scoreboard bench; expected requests are queued by stimulus, checked by a monitor.
module tb_dtm_dmi_access;
  localparam int ABITS = 7;
  localparam int W = ABITS + 34;
  typedef struct packed {
    logic [ABITS-1:0] a;
    logic [1:0]       op;
    logic [31:0]      d;
  } req_t;
  logic clk = 0, rst = 1;
  logic sel = 1, capture = 0, shift = 0, update = 0, tdi = 0, tdo;
  logic clear = 0, hardreset = 0;
  logic [1:0] status;
  logic rst_no;
  logic req_valid, req_ready = 0;
  logic [ABITS-1:0] req_addr;
  logic [1:0] req_op;
  logic [31:0] req_data;
  logic resp_valid = 0;
  logic [31:0] resp_data = 0;
  logic [1:0] resp_resp = 0;
  logic resp_ready;
  int compared = 0, mismatched = 0, pops = 0, rst_low = 0;
  req_t exp_q[$];
  logic [W-1:0] dout;
  int p0, r0;

  dtm_dmi_access #(.ABITS(ABITS)) dut (
    .clk_i(clk), .rst_i(rst), .dmi_select_i(sel), .capture_dr_i(capture),
    .shift_dr_i(shift), .update_dr_i(update), .tdi_i(tdi), .tdo_o(tdo),
    .dmi_clear_i(clear), .dmi_hardreset_i(hardreset), .dmi_status_o(status),
    .dmi_rst_no(rst_no), .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
    .dmi_req_addr_o(req_addr), .dmi_req_op_o(req_op), .dmi_req_data_o(req_data),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_data_i(resp_data),
    .dmi_resp_resp_i(resp_resp), .dmi_resp_ready_o(resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (req_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_req: got op %0d addr 0x%0h, required no request", req_op, req_addr);
      end else begin
        chk("req_addr", req_addr, exp_q[0].a);
        chk("req_op", req_op, exp_q[0].op);
        chk("req_data", req_data, exp_q[0].d);
        if (req_ready) void'(exp_q.pop_front());
      end
    end
    if (resp_ready) pops++;
    if (!rst_no) rst_low++;
  end

  function automatic logic [W-1:0] mk(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [1:0] op);
    return {a, d, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [W-1:0] din, input bit upd, output logic [W-1:0] so);
    tick();
    capture = 1;
    tick();
    capture = 0;
    shift = 1;
    for (int i = 0; i < W; i++) begin
      tdi = din[i];
      @(negedge clk) so[i] = tdo;
      tick();
    end
    shift = 0;
    if (upd) begin
      update = 1;
      tick();
      update = 0;
    end
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    int n = 0;
    resp_valid = 1;
    resp_data = d;
    resp_resp = r;
    @(negedge clk);
    while (!resp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_ready) chk("resp_pop_timeout", 0, 1);
    @(posedge clk);
    #1 resp_valid = 0;
  endtask

  task automatic pulse_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk("rst_tdo", tdo, 0);
    chk("rst_status", status, 0);
    chk("rst_rst_no", rst_no, 1);
    chk("rst_valid", req_valid, 0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_buses", {req_addr, req_op, req_data}, 0);
    rst = 0;
    // Read with back-pressure
    req_ready = 0;
    exp_q.push_back('{a: 7'h11, op: 2'd1, d: 32'h0});
    scan(mk(7'h11, 32'h0, 2'd1), 1, dout);
    @(negedge clk) chk("read_valid_latency", req_valid, 1);
    tick();
    tick();
    req_ready = 1;
    tick();
    req_ready = 0;
    p0 = pops;
    respond(32'hDEADBEEF, 2'd0);
    repeat (3) tick();
    chk("read_pops", pops - p0, 1);
    scan(mk(0, 0, 0), 0, dout);
    chk("read_capture", dout, mk(7'h11, 32'hDEADBEEF, 2'd0));
    chk("read_status", status, 0);
    // Write
    req_ready = 1;
    exp_q.push_back('{a: 7'h04, op: 2'd2, d: 32'h1});
    scan(mk(7'h04, 32'h1, 2'd2), 1, dout);
    @(negedge clk) chk("write_data", req_data, 32'h1);
    tick();
    respond(32'h55AA55AA, 2'd0);
    scan(mk(0, 0, 0), 0, dout);
    chk("write_capture", dout, mk(7'h04, 32'h1, 2'd0));
    chk("write_status", status, 0);
    // Busy: response withheld while the TAP keeps accessing
    exp_q.push_back('{a: 7'h22, op: 2'd1, d: 32'h0});
    scan(mk(7'h22, 32'h0, 2'd1), 1, dout);
    tick();
    tick();
    scan(mk(7'h33, 32'h0, 2'd1), 1, dout);
    @(negedge clk) chk("busy_status", status, 3);
    chk("busy_no_req", req_valid, 0);
    scan(mk(0, 0, 0), 0, dout);
    chk("busy_capture", dout, mk(7'h22, 32'h0, 2'd3));
    respond(32'h12345678, 2'd0);
    chk("busy_sticky", status, 3);
    scan(mk(7'h44, 32'h7, 2'd2), 1, dout);
    @(negedge clk) chk("busy_blocks_update", req_valid, 0);
    tick();
    pulse_clear();
    chk("busy_cleared", status, 0);
    exp_q.push_back('{a: 7'h44, op: 2'd2, d: 32'h7});
    scan(mk(7'h44, 32'h7, 2'd2), 1, dout);
    tick();
    respond(32'h0, 2'd0);
    chk("after_clear_status", status, 0);
    // Op failed, later busy code does not overwrite
    exp_q.push_back('{a: 7'h05, op: 2'd2, d: 32'hA5});
    scan(mk(7'h05, 32'hA5, 2'd2), 1, dout);
    tick();
    respond(32'h0, 2'd2);
    tick();
    chk("opfail_status", status, 2);
    p0 = pops;
    resp_valid = 1;
    resp_resp = 2'd3;
    repeat (3) tick();
    resp_valid = 0;
    chk("opfail_idle_no_pop", pops - p0, 0);
    chk("opfail_sticky", status, 2);
    pulse_clear();
    chk("opfail_cleared", status, 0);
    // Hardreset while WAIT_READ with a response pending
    exp_q.push_back('{a: 7'h06, op: 2'd1, d: 32'h0});
    scan(mk(7'h06, 32'h0, 2'd1), 1, dout);
    tick();
    p0 = pops;
    r0 = rst_low;
    hardreset = 1;
    resp_valid = 1;
    resp_resp = 2'd2;
    @(negedge clk) chk("hr_no_pop_now", resp_ready, 0);
    tick();
    hardreset = 0;
    resp_valid = 0;
    repeat (3) tick();
    chk("hr_rst_no_one_cycle", rst_low - r0, 1);
    chk("hr_no_pop", pops - p0, 0);
    chk("hr_status", status, 0);
    scan(mk(0, 0, 0), 0, dout);
    chk("hr_idle_capture", status, 0);
    // Asynchronous reset while a request is outstanding
    req_ready = 0;
    exp_q.push_back('{a: 7'h7F, op: 2'd2, d: 32'hFFFFFFFF});
    scan(mk(7'h7F, 32'hFFFFFFFF, 2'd2), 1, dout);
    scan(mk(0, 0, 2'd1), 0, dout);
    @(negedge clk);
    chk("pre_rst_valid", req_valid, 1);
    chk("pre_rst_status", status, 3);
    chk("pre_rst_tdo", tdo, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", req_valid, 0);
    chk("async_rst_buses", {req_addr, req_op, req_data}, 0);
    chk("async_rst_status", status, 0);
    chk("async_rst_tdo", tdo, 0);
    chk("async_rst_rst_no", rst_no, 1);
    chk("async_rst_resp_ready", resp_ready, 0);
    exp_q.delete();
    tick();
    rst = 0;
    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
